// File: rtl/dma_bus_arbiter_pkg.sv
// Shared encodings for the CPU/DMA memory bus arbiter: FSM states and 6502 RW levels.
package dma_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_CPU     = 2'd0,
    ST_STALL   = 2'd1,
    ST_DMA     = 2'd2,
    ST_RELEASE = 2'd3
  } arb_state_e;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // Bits needed to hold a count from 0 up to max_val inclusive.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/dma_bus_arbiter_fair_counter.sv
// Burst length and post-release CPU window counters for the bus arbiter.
module arb_fair_counter
  import dma_bus_arbiter_pkg::*;
#(
  parameter int MAX_BURST = 16,
  parameter int FAIR_GAP  = 4
) (
  input  logic clk,
  input  logic rst_ni,
  input  logic load_i,
  input  logic gap_dec_i,
  input  logic burst_inc_i,
  output logic burst_done_o,
  output logic gap_zero_o
);

  localparam int BW = cnt_width(MAX_BURST);
  localparam int GW = cnt_width(FAIR_GAP);

  logic [BW-1:0] burst_cnt_q, burst_cnt_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;

  assign gap_zero_o   = (gap_cnt_q == '0);
  // Asserted when the transfer happening now is the last one the grant allows.
  assign burst_done_o = burst_inc_i && (burst_cnt_q == BW'(MAX_BURST - 1));

  always_comb begin
    burst_cnt_d = burst_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    if (load_i) begin
      burst_cnt_d = '0;
      gap_cnt_d   = GW'(FAIR_GAP);
    end else begin
      if (burst_inc_i) burst_cnt_d = burst_cnt_q + 1'b1;
      if (gap_dec_i && !gap_zero_o) gap_cnt_d = gap_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      burst_cnt_q <= '0;
      gap_cnt_q   <= '0;
    end else begin
      burst_cnt_q <= burst_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
    end
  end

endmodule

// File: rtl/dma_bus_arbiter.sv
// Shares the memory bus between the 6502 core and one DMA master; the CPU is
// stalled via RDY and the bus only changes hands once the CPU is on a read.
module dma_bus_arbiter
  import dma_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 16,
  parameter int FAIR_GAP  = 4
) (
  input  logic              clk,
  input  logic              RST,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_rw,
  output logic              cpu_rdy,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  input  logic              dma_we,
  output logic              dma_gnt,
  output logic              dma_ack,
  output logic [DATA_W-1:0] dma_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_e state_q, state_d;
  logic              dma_ack_q;
  logic [DATA_W-1:0] dma_rdata_q;
  logic              xfer;
  logic              burst_done;
  logic              gap_zero;

  assign xfer = (state_q == ST_DMA) && dma_req;

  arb_fair_counter #(
    .MAX_BURST (MAX_BURST),
    .FAIR_GAP  (FAIR_GAP)
  ) u_fair_counter (
    .clk          (clk),
    .rst_ni       (RST),
    .load_i       (state_q == ST_RELEASE),
    .gap_dec_i    (state_q == ST_CPU),
    .burst_inc_i  (xfer),
    .burst_done_o (burst_done),
    .gap_zero_o   (gap_zero)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_CPU:     if (dma_req && gap_zero) state_d = ST_STALL;
      // The 6502 ignores RDY on writes, so only a read cycle means it is parked.
      ST_STALL: begin
        if (!dma_req)                 state_d = ST_CPU;
        else if (cpu_rw == RW_READ)   state_d = ST_DMA;
      end
      ST_DMA:     if (!dma_req || burst_done) state_d = ST_RELEASE;
      ST_RELEASE: state_d = ST_CPU;
      default:    state_d = ST_CPU;
    endcase
  end

  always_comb begin
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_we    = (cpu_rw == RW_WRITE);
    unique case (state_q)
      ST_DMA: begin
        mem_addr  = dma_addr;
        mem_wdata = dma_wdata;
        mem_we    = dma_req & dma_we;
      end
      ST_RELEASE: mem_we = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q     <= ST_CPU;
      dma_ack_q   <= 1'b0;
      dma_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      dma_ack_q <= xfer;
      if (xfer) dma_rdata_q <= mem_rdata;
    end
  end

  assign cpu_rdy   = (state_q == ST_CPU);
  assign dma_gnt   = (state_q == ST_DMA);
  assign dma_ack   = dma_ack_q;
  assign dma_rdata = dma_rdata_q;
  assign cpu_rdata = mem_rdata;

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Randomised and directed bench for dma_bus_arbiter against a transaction-level bus model.
module tb_dma_bus_arbiter;
  import dma_bus_arbiter_pkg::*;

  localparam int MAXB = 16;
  localparam int GAP  = 4;

  logic        clk = 1'b0;
  logic        RST;
  logic [15:0] cpu_addr, dma_addr, mem_addr;
  logic [7:0]  cpu_wdata, dma_wdata, mem_wdata, mem_rdata, cpu_rdata, dma_rdata;
  logic        cpu_rw, cpu_rdy, dma_req, dma_we, dma_gnt, dma_ack, mem_we;

  logic [7:0] mem     [0:65535];
  logic [7:0] ref_mem [0:65535];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dma_bus_arbiter #(.ADDR_W(16), .DATA_W(8), .MAX_BURST(MAXB), .FAIR_GAP(GAP)) dut (
    .clk(clk), .RST(RST),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rw(cpu_rw), .cpu_rdy(cpu_rdy),
    .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_we(dma_we),
    .dma_gnt(dma_gnt), .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

  function automatic logic [7:0] pat(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural bus model ----------------
  bit         granted = 0, stalled = 0, turning = 0;
  int         gap_left = 0, xfers = 0;
  bit         m_ack = 0;
  logic [7:0] m_rdata = 8'h00;
  logic [15:0] e_addr;
  logic [7:0]  e_wdata;
  logic        e_we, e_rdy, e_gnt;

  task automatic model_reset();
    granted = 0; stalled = 0; turning = 0;
    gap_left = 0; xfers = 0; m_ack = 0; m_rdata = 8'h00;
  endtask

  task automatic model_outputs();
    e_gnt = granted;
    e_rdy = !(granted || stalled || turning);
    if (granted) begin
      e_addr = dma_addr; e_wdata = dma_wdata; e_we = dma_req & dma_we;
    end else begin
      e_addr = cpu_addr; e_wdata = cpu_wdata; e_we = turning ? 1'b0 : (cpu_rw == RW_WRITE);
    end
  endtask

  task automatic model_step();
    if (!RST) model_reset();
    model_outputs();
    if (RST) begin
      m_ack = granted && dma_req;
      if (m_ack) m_rdata = ref_mem[dma_addr];
    end
    if (e_we) ref_mem[e_addr] = e_wdata;
    if (RST) begin
      if (turning) begin
        turning = 0; gap_left = GAP; xfers = 0;
      end else if (granted) begin
        if (dma_req) xfers++;
        if (!dma_req || xfers == MAXB) begin granted = 0; turning = 1; end
      end else if (stalled) begin
        if (!dma_req) stalled = 0;
        else if (cpu_rw == RW_READ) begin stalled = 0; granted = 1; end
      end else begin
        if (dma_req && gap_left == 0) stalled = 1;
        if (gap_left > 0) gap_left--;
      end
    end
  endtask

  always @(negedge RST) model_reset();
  always @(posedge clk) model_step();

  always @(negedge clk) begin
    model_outputs();
    chk("cpu_rdy",   32'(cpu_rdy),   32'(e_rdy));
    chk("dma_gnt",   32'(dma_gnt),   32'(e_gnt));
    chk("dma_ack",   32'(dma_ack),   32'(m_ack));
    chk("dma_rdata", 32'(dma_rdata), 32'(m_rdata));
    chk("mem_addr",  32'(mem_addr),  32'(e_addr));
    chk("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
    chk("mem_we",    32'(mem_we),    32'(e_we));
    chk("cpu_rdata", 32'(cpu_rdata), 32'(ref_mem[e_addr]));
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    dma_req = 1'b0;
    cpu_rw  = RW_READ;
    repeat (n) begin
      cpu_addr = 16'($urandom);
      step();
    end
  endtask

  int run, runs, ones;
  bit seen;

  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem[i]     = pat(16'(i));
      ref_mem[i] = pat(16'(i));
    end
    mem[16'h0200]     = 8'hA5;
    ref_mem[16'h0200] = 8'hA5;

    RST = 1'b0; cpu_addr = 16'h1234; cpu_wdata = 8'h00; cpu_rw = RW_READ;
    dma_req = 1'b0; dma_addr = 16'h0000; dma_wdata = 8'h00; dma_we = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_rdy",   32'(cpu_rdy),   32'd1);
      chk("rst_gnt",   32'(dma_gnt),   32'd0);
      chk("rst_ack",   32'(dma_ack),   32'd0);
      chk("rst_rdata", 32'(dma_rdata), 32'd0);
    end
    step();
    RST = 1'b1;

    // Idle: CPU owns the bus, writes land in 0x7000..0x7FFF.
    for (int c = 0; c < 50; c++) begin
      cpu_rw    = ($urandom_range(0, 3) == 0) ? RW_WRITE : RW_READ;
      cpu_addr  = (cpu_rw == RW_WRITE) ? 16'(16'h7000 | ($urandom & 32'h0FFF)) : 16'($urandom);
      cpu_wdata = 8'($urandom);
      @(negedge clk);
      chk("idle_rdy",  32'(cpu_rdy),  32'd1);
      chk("idle_addr", 32'(mem_addr), 32'(cpu_addr));
      step();
    end
    $display("phase idle done");
    idle(8);

    // Minimum-latency read of 0x0200.
    dma_req = 1'b1; dma_addr = 16'h0200; dma_we = 1'b0; cpu_rw = RW_READ;
    @(negedge clk); chk("min_rdy_e0", 32'(cpu_rdy), 32'd1);
    step(); @(negedge clk);
    chk("min_rdy_e1", 32'(cpu_rdy), 32'd0);
    chk("min_gnt_e1", 32'(dma_gnt), 32'd0);
    step(); @(negedge clk); chk("min_gnt_e2", 32'(dma_gnt), 32'd1);
    step(); dma_req = 1'b0;
    @(negedge clk);
    chk("min_ack",   32'(dma_ack),   32'd1);
    chk("min_rdata", 32'(dma_rdata), 32'hA5);
    $display("phase read 0x0200 done, rdata=%h", dma_rdata);
    idle(8);

    // Request while the CPU issues 3 writes (interrupt pushes).
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h3100; dma_wdata = 8'h77; cpu_rw = RW_READ;
    step();
    for (int i = 0; i < 3; i++) begin
      cpu_rw = RW_WRITE; cpu_addr = 16'(16'h3000 + i); cpu_wdata = 8'(8'h50 + i);
      @(negedge clk);
      chk("stall_we",  32'(mem_we),  32'd1);
      chk("stall_gnt", 32'(dma_gnt), 32'd0);
      step();
    end
    cpu_rw = RW_READ;
    @(negedge clk); chk("stall_rd_gnt", 32'(dma_gnt), 32'd0);
    step(); @(negedge clk); chk("stall_e5_gnt", 32'(dma_gnt), 32'd1);
    step(); dma_addr = 16'h3101; dma_wdata = 8'h78;
    step(); dma_req = 1'b0;
    idle(8);
    for (int i = 0; i < 3; i++) chk("push_mem", 32'(mem[16'h3000 + i]), 32'(8'h50 + i));
    chk("dma_wr0", 32'(mem[16'h3100]), 32'h77);
    $display("phase write-stall done");

    // Continuous request: alternating full bursts and CPU windows.
    dma_req = 1'b1; cpu_rw = RW_READ; run = 0; runs = 0; ones = 0; seen = 0;
    for (int c = 0; c < 60; c++) begin
      dma_we    = 1'($urandom);
      dma_addr  = 16'(16'h4000 | ($urandom & 32'h00FF));
      dma_wdata = 8'($urandom);
      cpu_addr  = 16'($urandom);
      @(negedge clk);
      if (dma_gnt) begin
        if (run == 0 && seen) chk("gap_rdy_ge", 32'(ones >= GAP), 32'd1);
        run++; ones = 0;
      end else begin
        if (run > 0) begin
          chk("burst_len", 32'(run), 32'(MAXB));
          $display("burst of %0d transfers", run);
          runs++; seen = 1; run = 0;
        end
        if (cpu_rdy) ones++;
      end
      step();
    end
    chk("burst_count", 32'(runs), 32'd2);
    idle(8);

    // Reset asserted during the 5th DMA write.
    dma_req = 1'b1; dma_we = 1'b1; cpu_rw = RW_READ; dma_addr = 16'h5000; dma_wdata = 8'hC0;
    step(); step();
    for (int k = 0; k < 4; k++) begin
      dma_addr = 16'(16'h5000 + k); dma_wdata = 8'(8'hC0 + k);
      step();
    end
    dma_addr = 16'h5004; dma_wdata = 8'hC4; RST = 1'b0;
    @(negedge clk);
    chk("rstmid_gnt", 32'(dma_gnt), 32'd0);
    chk("rstmid_rdy", 32'(cpu_rdy), 32'd1);
    chk("rstmid_ack", 32'(dma_ack), 32'd0);
    chk("rstmid_we",  32'(mem_we),  32'd0);
    step(); step();
    RST = 1'b1; dma_req = 1'b0;
    idle(3);
    @(negedge clk);
    chk("rstmid_cpu", 32'(cpu_rdy), 32'd1);
    chk("rstmid_mem4", 32'(mem[16'h5004]), 32'(pat(16'h5004)));
    chk("rstmid_mem3", 32'(mem[16'h5003]), 32'hC3);
    $display("phase reset mid-burst done");
    idle(8);

    // One-cycle request into STALL aborts with no gap.
    dma_req = 1'b1; cpu_rw = RW_WRITE; cpu_addr = 16'h6000; cpu_wdata = 8'h11;
    @(negedge clk); chk("pulse_rdy0", 32'(cpu_rdy), 32'd1);
    step(); dma_req = 1'b0; cpu_rw = RW_READ;
    @(negedge clk);
    chk("pulse_rdy1", 32'(cpu_rdy), 32'd0);
    chk("pulse_ack1", 32'(dma_ack), 32'd0);
    step();
    @(negedge clk);
    chk("pulse_rdy2", 32'(cpu_rdy), 32'd1);
    chk("pulse_ack2", 32'(dma_ack), 32'd0);
    dma_req = 1'b1; dma_we = 1'b0;
    step(); @(negedge clk); chk("pulse_regrant_stall", 32'(cpu_rdy), 32'd0);
    step(); @(negedge clk); chk("pulse_regrant_gnt", 32'(dma_gnt), 32'd1);
    step(); dma_req = 1'b0;
    idle(8);
    $display("phase pulse done");

    // Random traffic with occasional reset pulses.
    dma_req = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      cpu_addr  = 16'($urandom);
      cpu_wdata = 8'($urandom);
      cpu_rw    = ($urandom_range(0, 3) == 0) ? RW_WRITE : RW_READ;
      dma_addr  = 16'($urandom);
      dma_wdata = 8'($urandom);
      dma_we    = 1'($urandom);
      if ($urandom_range(0, 7) == 0) dma_req = ~dma_req;
      RST = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
      step();
    end
    RST = 1'b1;
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
